spi_flash_responder: RTL and testbench

- Synthesizable SPI flash target: the device end of the SPI master that boots the chip from external flash (o_flash_ss/sck/mosi, i_flash_miso).
- Used on the FPGA emulation board and in the chip-level testbench so boot images come from on-board BRAM instead of a physical flash part.
- Oversamples the SPI pins in the system clock domain, decodes flash read commands, fetches bytes from a byte-wide memory port and shifts them out in SPI mode 0.

---
 rtl/spi_flash_responder_pkg.sv | 26 ++
 rtl/spi_flash_responder_if.sv | 30 +++
 rtl/spi_flash_responder_pin_sync.sv | 61 ++++++
 rtl/spi_flash_responder.sv | 197 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, phase lengths and
// the FSM state type.
package spi_flash_responder_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ADDR_BITS  = 24;
    localparam int unsigned DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StIgnore
    } state_e;

    // True for the read opcodes this responder serves.
    function automatic logic is_supported(logic [7:0] op);
        return (op == CMD_READ) || (op == CMD_FAST_READ);
    endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// Byte-wide memory read port between the responder (master) and the backing
// store (slave).
//   mem_req   : read request, held until mem_ack
//   mem_addr  : byte address, stable while mem_req is high
//   mem_ack   : one-cycle acknowledge, mem_rdata valid in the same cycle
//   mem_rdata : read data byte
interface spi_flash_responder_if #(
    parameter int unsigned ADDR_W = 24
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/spi_flash_responder_pin_sync.sv
// Synchronizes the SPI pins into the system clock domain and derives edge
// strobes.
//   clk_i, rst_i          : system clock, synchronous active-high reset
//   ss_i, sck_i, mosi_i   : raw SPI pins
//   ss_o, mosi_o          : synchronized levels
//   ss_rise_o, ss_fall_o  : one-cycle strobes on synchronized ss edges
//   sck_rise_o/fall_o     : one-cycle strobes on sck edges, masked while ss high
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ss_i,
    input  logic sck_i,
    input  logic mosi_i,
    output logic ss_o,
    output logic mosi_o,
    output logic ss_rise_o,
    output logic ss_fall_o,
    output logic sck_rise_o,
    output logic sck_fall_o
);

    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   ss_prev_q;
    logic                   sck_prev_q;
    logic                   ss_s;
    logic                   sck_s;

    // ss resets to 0 (selected) on purpose: a reset in the middle of a frame
    // then produces no false falling edge, and a deselected master shows up
    // as a rising edge that re-arms the responder.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ss_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            ss_prev_q   <= ss_s;
            sck_prev_q  <= sck_s;
        end
    end

    assign ss_s  = ss_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];

    assign ss_o       = ss_s;
    assign mosi_o     = mosi_sync_q[SYNC_STAGES-1];
    assign ss_rise_o  = ss_s & ~ss_prev_q;
    assign ss_fall_o  = ~ss_s & ss_prev_q;
    assign sck_rise_o = ~ss_s & sck_s & ~sck_prev_q;
    assign sck_fall_o = ~ss_s & ~sck_s & sck_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash target (mode 0) serving READ (0x03) and FAST_READ (0x0B) from a
// byte-wide memory port, with a one-byte prefetch buffer.
//   wb_clk, wb_rst   : system clock (>= 8x sck), synchronous active-high reset
//   i_ss/i_sck/i_mosi: SPI pins from the master
//   o_miso, o_miso_oe: SPI data out and its enable (enable only in DATA)
//   mem              : memory read port (master side)
//   o_busy           : synchronized ss is low
//   o_underrun       : sticky, a byte was due before its fetch completed
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_DATA   = 8'hFF
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst,
    input  logic                          i_ss,
    input  logic                          i_sck,
    input  logic                          i_mosi,
    output logic                          o_miso,
    output logic                          o_miso_oe,
    output logic                          o_busy,
    output logic                          o_underrun,
    spi_flash_responder_if.master         mem
);

    localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
    localparam logic [4:0] ADDR_LAST  = 5'(ADDR_BITS - 1);
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_BITS - 1);

    logic ss_s, mosi_s, ss_rise, ss_fall, sck_rise, sck_fall;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk_i      (wb_clk),
        .rst_i      (wb_rst),
        .ss_i       (i_ss),
        .sck_i      (i_sck),
        .mosi_i     (i_mosi),
        .ss_o       (ss_s),
        .mosi_o     (mosi_s),
        .ss_rise_o  (ss_rise),
        .ss_fall_o  (ss_fall),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall)
    );

    state_e                 state_q;
    logic                   armed_q;
    logic [4:0]             bit_cnt_q;
    logic [ADDR_BITS-1:0]   shift_in_q;
    logic                   fast_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   mem_req_q;
    logic [7:0]             buf_q;
    logic                   buf_full_q;
    logic [7:0]             shift_out_q;
    logic [2:0]             out_cnt_q;
    logic                   miso_q;
    logic                   miso_oe_q;
    logic                   underrun_q;
    logic                   busy_q;

    logic [ADDR_BITS-1:0]   shift_in_next;
    logic [7:0]             load_byte;

    assign shift_in_next = {shift_in_q[ADDR_BITS-2:0], mosi_s};
    assign load_byte     = buf_full_q ? buf_q : IDLE_DATA;

    // addr_q always holds the address of the next fetch; it advances on ack,
    // so an underrun leaves the outstanding request (and its address) intact
    // and the late byte simply serves the following slot.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            fast_q      <= 1'b0;
            addr_q      <= '0;
            mem_req_q   <= 1'b0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            shift_out_q <= '0;
            out_cnt_q   <= '0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Not armed until ss has been seen high, so a frame cut by reset
            // stays ignored until the master starts a fresh one.
            busy_q <= armed_q & ~ss_s;

            if (ss_rise) begin
                state_q    <= StIdle;
                armed_q    <= 1'b1;
                mem_req_q  <= 1'b0;
                buf_full_q <= 1'b0;
                miso_oe_q  <= 1'b0;
                miso_q     <= 1'b1;
            end else if (ss_fall && armed_q) begin
                state_q    <= StCmd;
                bit_cnt_q  <= '0;
                fast_q     <= 1'b0;
                underrun_q <= 1'b0;
                buf_full_q <= 1'b0;
                mem_req_q  <= 1'b0;
                out_cnt_q  <= '0;
            end else begin
                unique case (state_q)
                    StCmd: begin
                        if (sck_rise) begin
                            shift_in_q <= shift_in_next;
                            if (bit_cnt_q == CMD_LAST) begin
                                bit_cnt_q <= '0;
                                fast_q    <= (shift_in_next[7:0] == CMD_FAST_READ);
                                state_q   <= is_supported(shift_in_next[7:0]) ? StAddr
                                                                              : StIgnore;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    StAddr: begin
                        if (sck_rise) begin
                            shift_in_q <= shift_in_next;
                            if (bit_cnt_q == ADDR_LAST) begin
                                bit_cnt_q <= '0;
                                addr_q    <= shift_in_next[ADDR_W-1:0];
                                if (fast_q) begin
                                    state_q <= StDummy;
                                end else begin
                                    state_q   <= StData;
                                    mem_req_q <= 1'b1;
                                    miso_oe_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    StDummy: begin
                        if (sck_rise) begin
                            if (bit_cnt_q == DUMMY_LAST) begin
                                bit_cnt_q <= '0;
                                state_q   <= StData;
                                mem_req_q <= 1'b1;
                                miso_oe_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    StData: begin
                        if (sck_fall) begin
                            if (out_cnt_q == 3'd0) begin
                                miso_q      <= load_byte[7];
                                shift_out_q <= {load_byte[6:0], 1'b0};
                                buf_full_q  <= 1'b0;
                                if (!buf_full_q) begin
                                    underrun_q <= 1'b1;
                                end
                                if (!mem_req_q) begin
                                    mem_req_q <= 1'b1;
                                end
                            end else begin
                                miso_q      <= shift_out_q[7];
                                shift_out_q <= {shift_out_q[6:0], 1'b0};
                            end
                            out_cnt_q <= out_cnt_q + 3'd1;
                        end
                        // Placed after the load so a same-cycle ack refills
                        // the buffer for the following byte.
                        if (mem_req_q && mem.mem_ack) begin
                            buf_q      <= mem.mem_rdata;
                            buf_full_q <= 1'b1;
                            mem_req_q  <= 1'b0;
                            addr_q     <= addr_q + ADDR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_miso       = miso_q;
    assign o_miso_oe    = miso_oe_q;
    assign o_busy       = busy_q;
    assign o_underrun   = underrun_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = addr_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

    logic wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    logic wb_rst, ss, sck, mosi;
    logic miso_a, oe_a, busy_a, under_a;
    logic miso_b, oe_b, busy_b, under_b;

    spi_flash_responder_if #(.ADDR_W(24)) mem_a ();
    spi_flash_responder_if #(.ADDR_W(8))  mem_b ();

    spi_flash_responder #(
        .ADDR_W      (24),
        .SYNC_STAGES (2),
        .IDLE_DATA   (8'hFF)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .i_ss       (ss),
        .i_sck      (sck),
        .i_mosi     (mosi),
        .o_miso     (miso_a),
        .o_miso_oe  (oe_a),
        .o_busy     (busy_a),
        .o_underrun (under_a),
        .mem        (mem_a)
    );

    spi_flash_responder #(
        .ADDR_W      (8),
        .SYNC_STAGES (2),
        .IDLE_DATA   (8'hFF)
    ) dut8 (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .i_ss       (ss),
        .i_sck      (sck),
        .i_mosi     (mosi),
        .o_miso     (miso_b),
        .o_miso_oe  (oe_b),
        .o_busy     (busy_b),
        .o_underrun (under_b),
        .mem        (mem_b)
    );

    logic [7:0]  mem [0:1023];
    int unsigned lat_a = 0;
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;
    bit          auto_a = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [23:0] req_a_q [$];
    logic [7:0]  req_b_q [$];
    bit          prev_a = 1'b0;
    bit          prev_b = 1'b0;
    bit          oe_seen = 1'b0;
    bit          miso_low_seen = 1'b0;

    logic [7:0] ra, rb;

    // Memory model for the 24-bit instance: ack after lat_a cycles of request.
    initial begin
        mem_a.mem_ack   = 1'b0;
        mem_a.mem_rdata = 8'h00;
        forever begin
            @(negedge wb_clk);
            if (auto_a) begin
                if (mem_a.mem_req && !mem_a.mem_ack) begin
                    if (cnt_a >= lat_a) begin
                        mem_a.mem_ack   = 1'b1;
                        mem_a.mem_rdata = mem[mem_a.mem_addr[9:0]];
                    end else begin
                        cnt_a++;
                    end
                end else begin
                    mem_a.mem_ack = 1'b0;
                    cnt_a = 0;
                end
            end
        end
    end

    // Zero-wait memory model for the 8-bit instance.
    initial begin
        mem_b.mem_ack   = 1'b0;
        mem_b.mem_rdata = 8'h00;
        forever begin
            @(negedge wb_clk);
            if (mem_b.mem_req && !mem_b.mem_ack) begin
                mem_b.mem_ack   = 1'b1;
                mem_b.mem_rdata = mem[{2'b00, mem_b.mem_addr}];
            end else begin
                mem_b.mem_ack = 1'b0;
            end
        end
    end

    // Records the address of every new request and watches the MISO pins.
    initial begin
        forever begin
            @(negedge wb_clk);
            if (mem_a.mem_req && !prev_a) req_a_q.push_back(mem_a.mem_addr);
            if (mem_b.mem_req && !prev_b) req_b_q.push_back(mem_b.mem_addr);
            prev_a = mem_a.mem_req;
            prev_b = mem_b.mem_req;
            if (oe_a) oe_seen = 1'b1;
            if (!miso_a) miso_low_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    // One mode-0 bit: sck period of 16 system clocks, MISO sampled at the rise.
    task automatic spi_bit(input logic b, output logic ro_a, output logic ro_b);
        mosi = b;
        ticks(8);
        ro_a = miso_a;
        ro_b = miso_b;
        sck = 1'b1;
        ticks(8);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx_a,
                            output logic [7:0] rx_b);
        logic x, y;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], x, y);
            rx_a[i] = x;
            rx_b[i] = y;
        end
    endtask

    task automatic send_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] da, db;
        spi_byte(cmd, da, db);
        spi_byte(a[23:16], da, db);
        spi_byte(a[15:8], da, db);
        spi_byte(a[7:0], da, db);
    endtask

    task automatic frame_start();
        req_a_q.delete();
        req_b_q.delete();
        oe_seen = 1'b0;
        miso_low_seen = 1'b0;
        ss = 1'b0;
        ticks(8);
    endtask

    task automatic frame_end();
        ticks(8);
        ss = 1'b1;
        ticks(16);
    endtask

    initial begin
        logic xa, xb;
        wb_rst = 1'b1;
        ss     = 1'b1;
        sck    = 1'b0;
        mosi   = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i ^ 8'h55);
        mem[10'h010] = 8'hDE;
        mem[10'h011] = 8'hAD;
        mem[10'h012] = 8'hBE;
        mem[10'h013] = 8'hEF;
        mem[10'h100] = 8'h5A;
        mem[10'h0FF] = 8'h3C;
        mem[10'h000] = 8'hC3;
        mem[10'h004] = 8'h96;
        mem[10'h005] = 8'h69;
        ticks(4);
        wb_rst = 1'b0;
        ticks(10);

        // Reset state
        check("rst_miso", 32'(miso_a), 32'd1);
        check("rst_oe", 32'(oe_a), 32'd0);
        check("rst_req", 32'(mem_a.mem_req), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_underrun", 32'(under_a), 32'd0);

        // READ at 0x10, zero-wait memory
        frame_start();
        send_cmd_addr(8'h03, 24'h000010);
        check("rd_busy", 32'(busy_a), 32'd1);
        spi_byte(8'h00, ra, rb); check("rd_byte0", 32'(ra), 32'hDE);
        spi_byte(8'h00, ra, rb); check("rd_byte1", 32'(ra), 32'hAD);
        spi_byte(8'h00, ra, rb); check("rd_byte2", 32'(ra), 32'hBE);
        spi_byte(8'h00, ra, rb); check("rd_byte3", 32'(ra), 32'hEF);
        check("rd_underrun", 32'(under_a), 32'd0);
        for (int i = 0; i < 5; i++) check("rd_addr", 32'(req_a_q[i]), 32'h10 + 32'(i));
        frame_end();
        check("rd_oe_after", 32'(oe_a), 32'd0);

        // FAST_READ at 0x100: nothing fetched until the dummy byte is done
        frame_start();
        send_cmd_addr(8'h0B, 24'h000100);
        check("fast_noreq", 32'(req_a_q.size()), 32'd0);
        spi_byte(8'h00, ra, rb);
        spi_byte(8'h00, ra, rb); check("fast_byte0", 32'(ra), 32'h5A);
        frame_end();

        // Address wrap on the 8-bit instance
        frame_start();
        send_cmd_addr(8'h03, 24'h0000FF);
        spi_byte(8'h00, ra, rb); check("wrap_byte0", 32'(rb), 32'h3C);
        spi_byte(8'h00, ra, rb); check("wrap_byte1", 32'(rb), 32'hC3);
        check("wrap_addr0", 32'(req_b_q[0]), 32'hFF);
        check("wrap_addr1", 32'(req_b_q[1]), 32'h00);
        frame_end();

        // Slow memory: first byte underruns
        lat_a = 40;
        frame_start();
        send_cmd_addr(8'h03, 24'h000020);
        spi_byte(8'h00, ra, rb); check("slow_byte0", 32'(ra), 32'hFF);
        check("slow_underrun", 32'(under_a), 32'd1);
        frame_end();
        check("slow_sticky", 32'(under_a), 32'd1);
        lat_a = 0;

        // Unsupported opcode; the ss fall also clears the sticky underrun
        frame_start();
        check("unsup_underrun_clr", 32'(under_a), 32'd0);
        send_cmd_addr(8'h9F, 24'h000010);
        spi_byte(8'h00, ra, rb);
        spi_byte(8'h00, ra, rb);
        check("unsup_busy", 32'(busy_a), 32'd1);
        frame_end();
        check("unsup_oe", 32'(oe_seen), 32'd0);
        check("unsup_miso", 32'(miso_low_seen), 32'd0);
        check("unsup_noreq", 32'(req_a_q.size()), 32'd0);

        // Abort after 12 address bits, then a stray ack while idle
        frame_start();
        spi_byte(8'h03, ra, rb);
        spi_byte(8'h00, ra, rb);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, xa, xb);
        frame_end();
        auto_a = 1'b0;
        mem_a.mem_ack   = 1'b1;
        mem_a.mem_rdata = 8'h77;
        ticks(1);
        mem_a.mem_ack = 1'b0;
        auto_a = 1'b1;
        ticks(4);
        check("abort_req", 32'(mem_a.mem_req), 32'd0);
        check("abort_oe", 32'(oe_a), 32'd0);

        frame_start();
        send_cmd_addr(8'h03, 24'h000004);
        spi_byte(8'h00, ra, rb); check("abort_rd0", 32'(ra), 32'h96);
        spi_byte(8'h00, ra, rb); check("abort_rd1", 32'(ra), 32'h69);

        // Reset pulse mid-DATA
        wb_rst = 1'b1;
        ticks(1);
        check("midrst_miso", 32'(miso_a), 32'd1);
        check("midrst_oe", 32'(oe_a), 32'd0);
        check("midrst_req", 32'(mem_a.mem_req), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        wb_rst = 1'b0;
        oe_seen = 1'b0;
        spi_byte(8'h00, ra, rb);
        spi_byte(8'h00, ra, rb);
        check("midrst_ignored", 32'(oe_seen), 32'd0);
        frame_end();

        // Fresh frame after the reset works again
        frame_start();
        send_cmd_addr(8'h03, 24'h000010);
        spi_byte(8'h00, ra, rb); check("post_rst_rd", 32'(ra), 32'hDE);
        frame_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
